// File: rtl/ifu_fetch_if.sv
// +----------------------------------------------------------------------+
// | ifu_fetch_if : PC / instruction-memory / decode signals of ifu_fetch |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface ifu_fetch_if #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] pc_i;
    logic              jump_i;
    logic              nop_o;
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_gnt_i;
    logic              imem_rvalid_i;
    logic [INST_W-1:0] imem_rdata_i;
    logic              id_valid_o;
    logic              id_ready_i;
    logic [INST_W-1:0] id_inst_o;
    logic [ADDR_W-1:0] id_pc_o;

    // Fetch-unit view
    modport master (
        input  pc_i, jump_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
        output nop_o, imem_req_o, imem_addr_o, id_valid_o, id_inst_o, id_pc_o
    );

    // Environment view (PC register, memory, decode)
    modport slave (
        output pc_i, jump_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
        input  nop_o, imem_req_o, imem_addr_o, id_valid_o, id_inst_o, id_pc_o
    );
endinterface

`default_nettype wire

// File: rtl/ifu_fetch.sv
// +----------------------------------------------------------------------+
// | ifu_fetch : in-order instruction fetch with credit limit and flush   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module ifu_fetch #(
    parameter int INST_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MAX_OUT = 2
) (
    input  logic            clk,
    input  logic            rstn,
    ifu_fetch_if.master     bus
);
    localparam logic [2:0] c_max_out = 3'(MAX_OUT);

    logic              r_run;
    logic [1:0]        r_out_cnt;
    logic [1:0]        r_drop_cnt;
    logic [1:0]        r_buf_cnt;
    logic [ADDR_W-1:0] r_addr_q [2];
    logic              r_addr_wr;
    logic              r_addr_rd;
    logic [INST_W-1:0] r_inst_q [2];
    logic [ADDR_W-1:0] r_ipc_q  [2];
    logic              r_buf_wr;
    logic              r_buf_rd;

    logic              w_id_valid;
    logic              w_pop;
    logic [2:0]        w_credit;
    logic              w_req;
    logic              w_acc;
    logic              w_drop_rsp;
    logic              w_keep_rsp;
    logic              w_any_rsp;
    logic [2:0]        w_flush_drop;

    assign w_id_valid = (r_buf_cnt != 2'd0) & ~bus.jump_i;
    assign w_pop      = w_id_valid & bus.id_ready_i;
    // Credits freed by this cycle's decode pop can be reused immediately.
    assign w_credit   = {1'b0, r_out_cnt} + {1'b0, r_buf_cnt} - {2'b00, w_pop};
    assign w_req      = r_run & ~bus.jump_i & (w_credit < c_max_out);
    assign w_acc      = w_req & bus.imem_gnt_i;

    assign w_drop_rsp = bus.imem_rvalid_i & (r_drop_cnt != 2'd0);
    assign w_keep_rsp = bus.imem_rvalid_i & (r_drop_cnt == 2'd0) & (r_out_cnt != 2'd0);
    assign w_any_rsp  = w_drop_rsp | w_keep_rsp;
    // On a flush every in-flight request becomes a discard, minus the one landing now.
    assign w_flush_drop = {1'b0, r_drop_cnt} + {1'b0, r_out_cnt} - {2'b00, w_any_rsp};

    assign bus.imem_req_o  = w_req;
    assign bus.imem_addr_o = bus.pc_i;
    assign bus.nop_o       = r_run & ~bus.jump_i & ~w_acc;
    assign bus.id_valid_o  = w_id_valid;
    assign bus.id_inst_o   = r_inst_q[r_buf_rd];
    assign bus.id_pc_o     = r_ipc_q[r_buf_rd];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_run       <= 1'b0;
            r_out_cnt   <= 2'd0;
            r_drop_cnt  <= 2'd0;
            r_buf_cnt   <= 2'd0;
            r_addr_q[0] <= '0;
            r_addr_q[1] <= '0;
            r_addr_wr   <= 1'b0;
            r_addr_rd   <= 1'b0;
            r_inst_q[0] <= '0;
            r_inst_q[1] <= '0;
            r_ipc_q[0]  <= '0;
            r_ipc_q[1]  <= '0;
            r_buf_wr    <= 1'b0;
            r_buf_rd    <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (bus.jump_i) begin
                r_out_cnt  <= 2'd0;
                r_buf_cnt  <= 2'd0;
                r_drop_cnt <= w_flush_drop[1:0];
                r_addr_wr  <= 1'b0;
                r_addr_rd  <= 1'b0;
                r_buf_wr   <= 1'b0;
                r_buf_rd   <= 1'b0;
            end else begin
                if (w_acc) begin
                    r_addr_q[r_addr_wr] <= bus.pc_i;
                    r_addr_wr           <= ~r_addr_wr;
                end
                if (w_keep_rsp) begin
                    r_inst_q[r_buf_wr] <= bus.imem_rdata_i;
                    r_ipc_q[r_buf_wr]  <= r_addr_q[r_addr_rd];
                    r_buf_wr           <= ~r_buf_wr;
                    r_addr_rd          <= ~r_addr_rd;
                end
                if (w_pop) begin
                    r_buf_rd <= ~r_buf_rd;
                end
                if (w_drop_rsp) begin
                    r_drop_cnt <= r_drop_cnt - 2'd1;
                end
                r_out_cnt <= r_out_cnt + {1'b0, w_acc} - {1'b0, w_keep_rsp};
                r_buf_cnt <= r_buf_cnt + {1'b0, w_keep_rsp} - {1'b0, w_pop};
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// +----------------------------------------------------------------------+
// | tb_ifu_fetch : directed bench with a 1-cycle-latency memory model    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ifu_fetch;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    ifu_fetch_if #(.INST_W(32), .ADDR_W(32)) bus ();

    ifu_fetch #(.INST_W(32), .ADDR_W(32), .MAX_OUT(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] pc;
    logic [31:0] pipe [$];
    bit          mem_hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: PC advances on acceptance, memory answers one cycle after grant.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = bus.imem_req_o & bus.imem_gnt_i;
        a   = bus.imem_addr_o;
        @(posedge clk);
        #1;
        if (acc) begin
            pipe.push_back(a);
            pc = pc + 32'd4;
        end
        bus.pc_i          = pc;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        if (!mem_hold && pipe.size() > 0) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = pipe.pop_front() ^ 32'hA5A5_0000;
        end
        #1;
    endtask

    task automatic do_reset(input logic [31:0] base);
        rstn = 1'b0;
        pipe.delete();
        mem_hold          = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.jump_i        = 1'b0;
        pc                = base;
        bus.pc_i          = base;
        #1;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int i;
        i = 0;
        while (!bus.id_valid_o && i < 10) begin
            tick();
            i++;
        end
        check(tag, 32'(bus.id_valid_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstn              = 1'b0;
        mem_hold          = 1'b0;
        pc                = '0;
        bus.pc_i          = '0;
        bus.jump_i        = 1'b0;
        bus.imem_gnt_i    = 1'b1;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.id_ready_i    = 1'b1;
        #12;
        check("rst_req",   32'(bus.imem_req_o), 32'd0);
        check("rst_nop",   32'(bus.nop_o),      32'd0);
        check("rst_valid", 32'(bus.id_valid_o), 32'd0);
        check("rst_inst",  bus.id_inst_o,       32'h0);
        check("rst_pc",    bus.id_pc_o,         32'h0);

        // Streaming from 0x0
        do_reset(32'h0);
        check("req_pre_run", 32'(bus.imem_req_o), 32'd0);
        tick();
        check("req_run", 32'(bus.imem_req_o), 32'd1);
        check("nop_run", 32'(bus.nop_o),      32'd0);
        tick();
        check("lat_t1_valid", 32'(bus.id_valid_o), 32'd0);
        tick();
        check("lat_t2_valid", 32'(bus.id_valid_o), 32'd1);
        check("lat_t2_pc",    bus.id_pc_o,         32'h0);
        check("lat_t2_inst",  bus.id_inst_o,       32'hA5A5_0000);
        for (int k = 1; k < 4; k++) begin
            tick();
            check("stream_valid", 32'(bus.id_valid_o), 32'd1);
            check("stream_pc",    bus.id_pc_o,         32'(4 * k));
            check("stream_inst",  bus.id_inst_o,       32'(4 * k) ^ 32'hA5A5_0000);
        end

        // Decode back-pressure fills the credits
        do_reset(32'h40);
        bus.id_ready_i = 1'b0;
        tick();
        tick();
        tick();
        check("bp_req",   32'(bus.imem_req_o), 32'd0);
        check("bp_nop",   32'(bus.nop_o),      32'd1);
        check("bp_valid", 32'(bus.id_valid_o), 32'd1);
        check("bp_pc",    bus.id_pc_o,         32'h40);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_req",  32'(bus.imem_req_o), 32'd0);
            check("bp_hold_inst", bus.id_inst_o,       32'hA5A5_0040);
        end
        bus.id_ready_i = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("drain_valid", 32'(bus.id_valid_o), 32'd1);
            check("drain_pc",    bus.id_pc_o,         32'h40 + 32'(4 * k));
            tick();
        end

        // Grant withheld for three cycles
        bus.imem_gnt_i = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("nognt_nop",  32'(bus.nop_o), 32'd1);
            check("nognt_addr", bus.imem_addr_o, 32'h58);
            tick();
        end
        bus.imem_gnt_i = 1'b1;
        #1;
        check("gnt_back_nop", 32'(bus.nop_o),      32'd0);
        check("gnt_back_req", 32'(bus.imem_req_o), 32'd1);
        tick();
        tick();
        check("gnt_back_pc", bus.id_pc_o, 32'h58);

        // Jump with two requests outstanding and no response yet
        do_reset(32'h10);
        mem_hold = 1'b1;
        tick();
        tick();
        tick();
        check("full_req", 32'(bus.imem_req_o), 32'd0);
        check("full_nop", 32'(bus.nop_o),      32'd1);
        bus.jump_i = 1'b1;
        mem_hold   = 1'b0;
        #1;
        check("jmp_nop",   32'(bus.nop_o),      32'd0);
        check("jmp_req",   32'(bus.imem_req_o), 32'd0);
        check("jmp_valid", 32'(bus.id_valid_o), 32'd0);
        tick();
        bus.jump_i = 1'b0;
        pc         = 32'h100;
        bus.pc_i   = 32'h100;
        check("jmp_drop", 32'(dut.r_drop_cnt), 32'd2);
        wait_valid("jmp_wait");
        check("jmp_first_pc",   bus.id_pc_o,   32'h100);
        check("jmp_first_inst", bus.id_inst_o, 32'hA5A5_0100);

        // Jump in the cycle 0x20 returns while 0x24 is outstanding
        do_reset(32'h20);
        mem_hold = 1'b1;
        tick();
        tick();
        mem_hold = 1'b0;
        tick();
        check("jr_rvalid", 32'(bus.imem_rvalid_i), 32'd1);
        bus.jump_i = 1'b1;
        tick();
        bus.jump_i = 1'b0;
        pc         = 32'h200;
        bus.pc_i   = 32'h200;
        check("jr_drop1", 32'(dut.r_drop_cnt), 32'd1);
        tick();
        check("jr_drop0", 32'(dut.r_drop_cnt), 32'd0);
        wait_valid("jr_wait");
        check("jr_first_pc", bus.id_pc_o, 32'h200);

        // Reset with one request outstanding, then a stray response
        do_reset(32'h300);
        mem_hold = 1'b1;
        tick();
        tick();
        rstn = 1'b0;
        #1;
        check("arst_req",   32'(bus.imem_req_o), 32'd0);
        check("arst_valid", 32'(bus.id_valid_o), 32'd0);
        @(posedge clk);
        #1;
        rstn     = 1'b1;
        pipe.delete();
        mem_hold = 1'b0;
        pc       = 32'h400;
        bus.pc_i = 32'h400;
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'h300 ^ 32'hA5A5_0000;
        tick();
        check("stray_valid", 32'(bus.id_valid_o), 32'd0);
        tick();
        check("stray_valid2", 32'(bus.id_valid_o), 32'd0);
        wait_valid("stray_wait");
        check("stray_first_pc", bus.id_pc_o, 32'h400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
